// File: rtl/io_input_bank.sv
// Memory-mapped input bank: NUM_PORTS synchronised, debounced input ports and a sticky change-status word.
// Optional feature macro IO_IN_IRQ_EN adds a registered, maskable irq output driven from the status word.
module io_input_bank #(
    parameter int                   NUM_PORTS    = 2,
    parameter int                   DATA_W       = 32,
    parameter logic [5:0]           BASE_SEL     = 6'h30,
    parameter int                   DEBOUNCE_CYC = 4,
    parameter logic [NUM_PORTS-1:0] IRQ_MASK     = '1
) (
    input  logic                          io_clk,
    input  logic                          reset,
    input  logic [31:0]                   addr,
    input  logic                          rd_en,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_port,
    output logic [31:0]                   io_read_data
`ifdef IO_IN_IRQ_EN
   ,output logic                          irq
`endif
);

    localparam int                CNT_W      = (DEBOUNCE_CYC <= 1) ? 1 : $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [5:0]        STATUS_SEL = 6'(BASE_SEL + NUM_PORTS);

    logic [DATA_W-1:0]    sync1  [NUM_PORTS];
    logic [DATA_W-1:0]    sync2  [NUM_PORTS];
    logic [DATA_W-1:0]    stable [NUM_PORTS];
    logic [CNT_W-1:0]     cnt    [NUM_PORTS];
    logic [NUM_PORTS-1:0] status;
    logic [NUM_PORTS-1:0] status_next;
    logic [NUM_PORTS-1:0] accept;
    logic [5:0]           sel;
    logic                 status_clr;

    assign sel = addr[7:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:8], addr[1:0]};

    // Acceptance fires when a differing value has persisted for DEBOUNCE_CYC edges.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        accept = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
        status_clr  = rd_en && (sel == STATUS_SEL);
        // Set wins over a coincident clear so no change event is lost.
        status_next = (status & ~{NUM_PORTS{status_clr}}) | accept;
    end

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            // NOTE: the small per-port arrays are register banks, not RAM, so they are reset element by element.
            for (int i = 0; i < NUM_PORTS; i++) begin
                sync1[i]  <= '0;
                sync2[i]  <= '0;
                stable[i] <= '0;
                cnt[i]    <= '0;
            end
            status <= '0;
        end else begin
            // NOTE: non-blocking assignments keep the sync1 -> sync2 -> stable chain a true pipeline.
            for (int i = 0; i < NUM_PORTS; i++) begin
                sync1[i] <= in_port[i*DATA_W +: DATA_W];
                sync2[i] <= sync1[i];
                if (accept[i]) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else if (sync2[i] != stable[i]) begin
                    cnt[i]    <= cnt[i] + 1'b1;
                end else begin
                    cnt[i]    <= '0;
                end
            end
            status <= status_next;
        end
    end

    always_comb begin
        io_read_data = 32'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel == 6'(BASE_SEL + i)) begin
                io_read_data = 32'(stable[i]);
            end
        end
        if (sel == STATUS_SEL) begin
            io_read_data = 32'(status);
        end
    end

`ifdef IO_IN_IRQ_EN
    // Registered from status_next so irq tracks status on the same edge.
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(status_next & IRQ_MASK);
        end
    end
`else
    localparam logic [NUM_PORTS-1:0] unused_irq_mask = IRQ_MASK;
`endif

endmodule

// File: tb/tb_io_input_bank.sv
// Self-checking bench for io_input_bank: directed steps, then random stimulus against a behavioural model.
module tb_io_input_bank;

    localparam int DC = 4;

    logic        io_clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        rd_en;
    logic [63:0] in_port;
    logic [31:0] io_read_data;
    logic [7:0]  in8;
    logic [31:0] read8;
`ifdef IO_IN_IRQ_EN
    logic        irq;
    logic        irq8;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    logic [31:0] m_s1 [2];
    logic [31:0] m_s2 [2];
    logic [31:0] m_st [2];
    int          m_run [2];
    logic [1:0]  m_stat;
    logic        m_irq;

    io_input_bank dut (
        .io_clk       (io_clk),
        .reset        (reset),
        .addr         (addr),
        .rd_en        (rd_en),
        .in_port      (in_port),
        .io_read_data (io_read_data)
`ifdef IO_IN_IRQ_EN
       ,.irq          (irq)
`endif
    );

    io_input_bank #(.NUM_PORTS(1), .DATA_W(8)) dut8 (
        .io_clk       (io_clk),
        .reset        (reset),
        .addr         (addr),
        .rd_en        (rd_en),
        .in_port      (in8),
        .io_read_data (read8)
`ifdef IO_IN_IRQ_EN
       ,.irq          (irq8)
`endif
    );

    always #5 io_clk = ~io_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_s1[p] = '0; m_s2[p] = '0; m_st[p] = '0; m_run[p] = 0;
        end
        m_stat = '0;
        m_irq  = 1'b0;
    endtask

    // One clock edge of the spec's rules, evaluated from pre-edge inputs.
    task automatic model_step();
        logic [1:0] set;
        logic       clr;
        set = '0;
        for (int p = 0; p < 2; p++) begin
            if (m_s2[p] !== m_st[p]) begin
                m_run[p]++;
                if (m_run[p] == DC) begin
                    m_st[p]  = m_s2[p];
                    m_run[p] = 0;
                    set[p]   = 1'b1;
                end
            end else begin
                m_run[p] = 0;
            end
        end
        clr    = rd_en && (addr[7:2] == 6'h32);
        m_stat = clr ? set : (m_stat | set);
        m_irq  = |m_stat;
        for (int p = 0; p < 2; p++) begin
            m_s2[p] = m_s1[p];
            m_s1[p] = in_port[p*32 +: 32];
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a[7:2])
            6'h30:   return m_st[0];
            6'h31:   return m_st[1];
            6'h32:   return {30'd0, m_stat};
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        model_step();
        @(posedge io_clk);
        #1;
    endtask

    task automatic read_at(input logic [5:0] s);
        addr = {24'd0, s, 2'b00};
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        rd_en   = 1'b0;
        addr    = 32'h0000_00C0;
        in_port = {32'h0, 32'hDEAD_BEEF};
        in8     = 8'hAC;
        model_reset();
        @(posedge io_clk);
        #1;
        check("reset_port0", io_read_data, 32'h0);
        read_at(6'h32);
        check("reset_status", io_read_data, 32'h0);
        reset = 1'b0;

        // Reset release with port0 held: visible only after the 6th edge.
        read_at(6'h30);
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("latency_edge%0d", e), io_read_data, 32'h0);
        end
        tick();
        check("latency_edge6", io_read_data, 32'hDEAD_BEEF);
        read_at(6'h32);
        check("status_after_accept", io_read_data, 32'h1);
        addr = 32'h0000_00C0;
        #1;
        check("dw8_read", read8, 32'h0000_00AC);
`ifdef IO_IN_IRQ_EN
        check("irq_after_accept", {31'd0, irq}, 32'h1);
`endif

        // Short pulse on port1 is filtered.
        in_port[63:32] = 32'h5;
        for (int e = 0; e < 3; e++) tick();
        in_port[63:32] = 32'h0;
        for (int e = 0; e < 8; e++) tick();
        read_at(6'h31);
        check("glitch_port1", io_read_data, 32'h0);
        read_at(6'h32);
        check("glitch_status", io_read_data, 32'h1);

        // Clear-on-read of status.
        rd_en = 1'b1;
        read_at(6'h32);
        check("status_read_cycle", io_read_data, 32'h1);
        tick();
        rd_en = 1'b0;
        #1;
        check("status_after_clear", io_read_data, 32'h0);
`ifdef IO_IN_IRQ_EN
        check("irq_after_clear", {31'd0, irq}, 32'h0);
`endif

        // Acceptance coincides with a clearing read: set wins.
        in_port[31:0] = 32'h0000_1234;
        for (int e = 0; e < 5; e++) tick();
        check("status_pre_coincide", io_read_data, 32'h0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        #1;
        check("status_coincide", io_read_data, 32'h1);
`ifdef IO_IN_IRQ_EN
        check("irq_coincide", {31'd0, irq}, 32'h1);
`endif

        // Unmapped selects read zero.
        read_at(6'h00);
        check("unmapped_00", io_read_data, 32'h0);
        read_at(6'h33);
        check("unmapped_33", io_read_data, 32'h0);

        // Reset mid-count restarts the full latency.
        in_port[31:0] = 32'h0000_0055;
        for (int e = 0; e < 4; e++) tick();
        reset = 1'b1;
        #1;
        model_reset();
        read_at(6'h30);
        check("midreset_port0", io_read_data, 32'h0);
        read_at(6'h32);
        check("midreset_status", io_read_data, 32'h0);
        @(negedge io_clk);
        reset = 1'b0;
        read_at(6'h30);
        for (int e = 0; e < 5; e++) tick();
        check("midreset_edge5", io_read_data, 32'h0);
        tick();
        check("midreset_edge6", io_read_data, 32'h0000_0055);

        // Random stimulus against the model.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_port[p*32 +: 32] = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3));
                end
            end
            case ($urandom_range(0, 4))
                0:       addr = 32'h0000_00C0;
                1:       addr = 32'h0000_00C4;
                2:       addr = 32'h0000_00C8 | 32'($urandom_range(0, 3));
                3:       addr = 32'h0000_00C8;
                default: addr = $urandom;
            endcase
            rd_en = ($urandom_range(0, 3) == 0);
            #1;
            check($sformatf("rand_read_%0d", n), io_read_data, model_read(addr));
            tick();
`ifdef IO_IN_IRQ_EN
            check($sformatf("rand_irq_%0d", n), {31'd0, irq}, {31'd0, m_irq});
`endif
        end
        rd_en = 1'b0;
        read_at(6'h32);
        check("final_status", io_read_data, {30'd0, m_stat});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/io_input_bank.md
Name: io_input_bank

Overview:
Parametrised successor to the two-port input register. Samples NUM_PORTS external input ports of DATA_W bits each through a two-flop synchroniser and a per-port debounce filter, and keeps a sticky per-port change-status register. Contents are exposed to the pipeline's memory-mapped I/O read path through word-address decode of addr[7:2]. Sits beside the data-memory read mux, as the existing input block does.

Parameters:
NUM_PORTS, 2, number of input ports (1..8)
DATA_W, 32, width of each input port (1..32)
BASE_SEL, 6'h30, addr[7:2] value of port 0; port i at BASE_SEL+i; requires BASE_SEL+NUM_PORTS <= 63
DEBOUNCE_CYC, 4, consecutive synchronised cycles a new value must persist before acceptance (>=1)
IRQ_MASK, all ones (NUM_PORTS bits), ports allowed to raise irq (used only with the optional feature)

Ports:
io_clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
addr  in  32  byte address; only addr[7:2] decoded
rd_en  in  1  I/O read strobe; qualifies clear-on-read of status
in_port  in  NUM_PORTS*DATA_W  packed asynchronous inputs; port i = bits [i*DATA_W +: DATA_W]
io_read_data  out  32  combinational read data
irq  out  1  present only with IO_IN_IRQ_EN

Behaviour:
- Reset (async, active-high): sync1, sync2, stable, debounce counters, status and irq all cleared to 0. io_read_data follows decode of the cleared registers (0 for any selected port).
- Synchroniser: every io_clk rising edge, sync1[i] <= in_port[i] and sync2[i] <= sync1[i].
- Debounce, per port, every edge:
  - If sync2[i] != stable[i] and cnt[i] == DEBOUNCE_CYC-1: stable[i] <= sync2[i], cnt[i] <= 0, chg[i] set.
  - Else if sync2[i] != stable[i]: cnt[i] <= cnt[i]+1.
  - Else: cnt[i] <= 0.
- A glitch that returns to the stable value before acceptance resets the count and produces no change.
- If the value changes to a different non-stable value mid-count, counting continues; the value present at the accepting edge is taken.
- Latency: a value held constant from capture edge k becomes visible in stable/io_read_data after edge k+DEBOUNCE_CYC+1 (DEBOUNCE_CYC+2 edges total; 6 for the default).
- Counter width: clog2(DEBOUNCE_CYC), minimum 1 bit. Counter never wraps.
- Status register: status[i] set on that port's acceptance edge. Cleared on an edge where rd_en=1 and addr[7:2]==BASE_SEL+NUM_PORTS. Set has priority over clear in the same cycle, so no event is lost. Bits NUM_PORTS..31 read 0.
- Read decode (combinational, same cycle as addr):
  - sel = BASE_SEL+i: {zero-extend to 32, stable[i]}
  - sel = BASE_SEL+NUM_PORTS: {zeros, status}
  - any other sel: 32'd0
- rd_en does not gate io_read_data. It only qualifies the status clear.

Optional Feature:
IO_IN_IRQ_EN
- Defined: irq port exists. irq is a register, irq <= |(status_next & IRQ_MASK), where status_next is the value status takes at that edge. It therefore asserts on the edge that sets status and drops on the edge that clears it. Reset 0.
- Undefined: no irq port and no irq logic. IRQ_MASK is unused.

Test Plan:
- Reset release with in_port port0=32'hDEADBEEF held -> port0 read (sel 6'h30) = 0 through edge 5, 32'hDEADBEEF after edge 6; status reads 32'h1.
- Port1 pulse 32'h5 lasting 3 cycles from stable 0 (DEBOUNCE_CYC=4) -> port1 read (6'h31) stays 0; status bit1 stays 0.
- Read status (sel 6'h32, rd_en=1) after port0 change -> returns 32'h1 that cycle; reads 32'h0 after the edge.
- Port0 acceptance edge coincides with status clear read -> status still 32'h1 afterwards; irq stays 1 with IO_IN_IRQ_EN.
- Unmapped sel 6'h00 and 6'h33 -> io_read_data = 32'h0. DATA_W=8 with port0 input 8'hAC -> read 32'h000000AC.
- Assert reset mid-count (cnt=2) -> stable, cnt and status 0 immediately. After release, the value needs the full DEBOUNCE_CYC+2 edges again.
